// File: rtl/rle_pkg.sv
// Shared types, width derivation and record packing for the parametrised RLE encoder.
// Optional output-overflow guard is enabled with the RLE_OVF_CHECK_EN macro (see rle_encoder_param).
package rle_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned ADDR_W     = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SCAN,
        S_EMIT,
        S_FINISH
    } rle_state_e;

    function automatic int unsigned rec_width(input int unsigned sym_w, input int unsigned cnt_w);
        return sym_w + cnt_w;
    endfunction

    function automatic int unsigned recs_per_word(input int unsigned rec_w);
        return WORD_W / rec_w;
    endfunction

    function automatic bit cfg_legal(input int unsigned sym_w, input int unsigned cnt_w);
        int unsigned rec_w;
        rec_w = sym_w + cnt_w;
        return ((sym_w == 8) || (sym_w == 16)) && (cnt_w > 0) &&
               ((rec_w == 16) || (rec_w == 32));
    endfunction

    // Place rec into record slot 'slot' of word; other slots are kept as they are.
    function automatic logic [WORD_W-1:0] rec_pack(input logic [WORD_W-1:0] word,
                                                   input logic [1:0]        slot,
                                                   input int unsigned       rec_w,
                                                   input logic [WORD_W-1:0] rec);
        logic [WORD_W-1:0] mask;
        int unsigned       sh;
        mask = (rec_w >= WORD_W) ? '1 : ((32'h1 << rec_w) - 32'h1);
        sh   = {30'b0, slot} * rec_w;
        return (word & ~(mask << sh)) | ((rec & mask) << sh);
    endfunction

endpackage

// File: rtl/rle_rec_packer.sv
// Accumulates {symbol, count} records little-endian into one 32-bit output word.
// Reports fill level; cleared by the encoder after every write.
module rle_rec_packer
    import rle_pkg::*;
#(
    parameter int unsigned SYM_W = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          push,
    input  logic [SYM_W+CNT_W-1:0]        rec,
    output logic [WORD_W-1:0]             word,
    output logic [1:0]                    fill,
    output logic                          last_slot,
    output logic                          empty
);

    localparam int unsigned REC_W = rec_width(SYM_W, CNT_W);
    localparam int unsigned RPW   = recs_per_word(REC_W);

    logic [WORD_W-1:0] word_q;
    logic [1:0]        fill_q;

    // Buffer must start from zero so unused slots flush as zero padding.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q <= '0;
            fill_q <= '0;
        end else if (clear) begin
            word_q <= '0;
            fill_q <= '0;
        end else if (push) begin
            word_q <= rec_pack(word_q, fill_q, REC_W, WORD_W'(rec));
            fill_q <= fill_q + 2'd1;
        end
    end

    assign word      = word_q;
    assign fill      = fill_q;
    assign last_slot = (fill_q == 2'(RPW - 1));
    assign empty     = (fill_q == 2'd0);

endmodule

// File: rtl/rle_encoder_param.sv
// Run-length encoder over a shared single-port RAM: reads symbols, writes packed {symbol, count} records.
// Define RLE_OVF_CHECK_EN to abort with error=1 when a write would exceed rle_max_size.
module rle_encoder_param
    import rle_pkg::*;
#(
    parameter int unsigned SYM_W = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] message_addr,
    input  logic [31:0] message_size,
    input  logic [31:0] rle_addr,
    input  logic [31:0] rle_max_size,
    output logic [31:0] rle_size,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        port_A_clk,
    output logic [15:0] port_A_addr,
    output logic [31:0] port_A_data_in,
    input  logic [31:0] port_A_data_out,
    output logic        port_A_we
);

    localparam int unsigned REC_W = rec_width(SYM_W, CNT_W);
    localparam int unsigned SPW   = WORD_W / SYM_W;
    localparam int unsigned IDX_W = $clog2(SPW);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (!cfg_legal(SYM_W, CNT_W)) begin : g_bad_cfg
        $error("rle_encoder_param: illegal SYM_W/CNT_W combination");
    end

    rle_state_e        state;
    logic [15:0]       rd_ptr;
    logic [15:0]       wr_ptr;
    logic [31:0]       remaining;
    logic [31:0]       word_q;
    logic [IDX_W-1:0]  sym_idx;
    logic [SYM_W-1:0]  run_sym;
    logic [CNT_W-1:0]  run_cnt;
    logic              run_vld;
    logic              error_q;

    logic [31:0]       word_shift;
    logic [SYM_W-1:0]  cur_sym;
    logic              extend;
    logic              push;
    logic              last_sym;
    logic              word_end;
    logic              ovf;
    logic              fin_has;
    logic [31:0]       fin_word;
    logic              pkr_clear;
    logic [31:0]       pkr_word;
    logic [1:0]        pkr_fill;
    logic              pkr_last_slot;
    logic              pkr_empty;
    logic              unused_ok;

    assign unused_ok = ^{message_addr[31:16], rle_addr[31:16], rle_max_size};

    assign word_shift = word_q >> (32'(sym_idx) * SYM_W);
    assign cur_sym    = word_shift[SYM_W-1:0];
    assign last_sym   = (remaining == 32'd1);
    assign word_end   = (sym_idx == IDX_W'(SPW - 1));
    // A run closes lazily: only when the next symbol cannot extend it.
    assign extend     = run_vld && (cur_sym == run_sym) && (run_cnt != CNT_MAX);
    assign push       = (state == S_SCAN) && run_vld && !extend;

    assign fin_has  = run_vld || !pkr_empty;
    assign fin_word = run_vld ? rec_pack(pkr_word, pkr_fill, REC_W, WORD_W'({run_sym, run_cnt}))
                              : pkr_word;

`ifdef RLE_OVF_CHECK_EN
    assign ovf   = ({1'b0, rle_size} + 33'd4) > {1'b0, rle_max_size};
    assign error = error_q;
`else
    assign ovf   = 1'b0;
    assign error = 1'b0;
`endif

    assign port_A_clk     = clk;
    assign port_A_we      = ((state == S_EMIT) ||
                             ((state == S_FINISH) && fin_has && !error_q)) && !ovf;
    assign port_A_addr    = port_A_we ? wr_ptr : rd_ptr;
    assign port_A_data_in = !port_A_we          ? 32'd0 :
                            (state == S_EMIT)   ? pkr_word : fin_word;

    assign pkr_clear = (state == S_EMIT) || (state == S_FINISH) || ((state == S_IDLE) && start);

    rle_rec_packer #(
        .SYM_W (SYM_W),
        .CNT_W (CNT_W)
    ) u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (pkr_clear),
        .push      (push),
        .rec       ({run_sym, run_cnt}),
        .word      (pkr_word),
        .fill      (pkr_fill),
        .last_slot (pkr_last_slot),
        .empty     (pkr_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            error_q   <= 1'b0;
            rle_size  <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            remaining <= '0;
            word_q    <= '0;
            sym_idx   <= '0;
            run_sym   <= '0;
            run_cnt   <= '0;
            run_vld   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        error_q   <= 1'b0;
                        rle_size  <= '0;
                        rd_ptr    <= message_addr[15:0];
                        wr_ptr    <= rle_addr[15:0];
                        remaining <= message_size;
                        run_vld   <= 1'b0;
                        state     <= (message_size != 32'd0) ? S_FETCH : S_FINISH;
                    end
                end
                S_FETCH: state <= S_LOAD;
                S_LOAD: begin
                    word_q  <= port_A_data_out;
                    rd_ptr  <= rd_ptr + 16'd4;
                    sym_idx <= '0;
                    state   <= S_SCAN;
                end
                S_SCAN: begin
                    if (extend) begin
                        run_cnt <= run_cnt + CNT_W'(1);
                    end else begin
                        run_sym <= cur_sym;
                        run_cnt <= CNT_W'(1);
                        run_vld <= 1'b1;
                    end
                    remaining <= remaining - 32'd1;
                    sym_idx   <= sym_idx + IDX_W'(1);
                    if (push && pkr_last_slot)
                        state <= S_EMIT;
                    else if (last_sym)
                        state <= S_FINISH;
                    else if (word_end)
                        state <= S_FETCH;
                end
                S_EMIT: begin
                    if (ovf) begin
                        error_q <= 1'b1;
                        state   <= S_FINISH;
                    end else begin
                        wr_ptr   <= wr_ptr + 16'd4;
                        rle_size <= rle_size + 32'd4;
                        // sym_idx wraps to zero once the current word is used up
                        if (remaining == 32'd0)
                            state <= S_FINISH;
                        else if (sym_idx == '0)
                            state <= S_FETCH;
                        else
                            state <= S_SCAN;
                    end
                end
                S_FINISH: begin
                    if (fin_has && !error_q) begin
                        if (ovf) begin
                            error_q <= 1'b1;
                        end else begin
                            wr_ptr   <= wr_ptr + 16'd4;
                            rle_size <= rle_size + 32'd4;
                        end
                    end
                    run_vld <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/rle_encoder_param.md
# rle_encoder_param

- Parametrised run-length encoder.
- Reads a symbol stream from the shared single-port DPSRAM (port A), splits it into runs, and writes packed {symbol, count} records back to the same RAM.
- Next-generation replacement for the fixed 8-bit byte encoder. Adds configurable symbol/count widths, saturation run splitting, odd-record flush with zero padding, a busy/done handshake, and an optional output-overflow guard.

## Interface
- SYM_W, 8: symbol width in bits. Legal values are 8 and 16.
- CNT_W, 8: run-count field width. SYM_W+CNT_W (REC_W) must be 16 or 32.
- clk  in  1  system clock; also drives port_A_clk.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; sampled only while busy=0.
- message_addr  in  32  byte address of the first input word; bits [15:0] are used.
- message_size  in  32  input length in symbols.
- rle_addr  in  32  byte address of the first output word; bits [15:0] are used.
- rle_max_size  in  32  output limit in bytes; used only with RLE_OVF_CHECK_EN.
- rle_size  out  32  bytes written, always 4 × words written.
- busy  out  1  high from the cycle after start until done.
- done  out  1  level; high after completion until the next accepted start.
- error  out  1  overflow abort flag; tied to 0 without RLE_OVF_CHECK_EN.
- port_A_clk  out  1  equal to clk.
- port_A_addr  out  16  RAM byte address.
- port_A_data_in  out  32  RAM write data.
- port_A_data_out  in  32  RAM read data. Synchronous, valid one cycle after the address.
- port_A_we  out  1  RAM write enable.

## Operation
- States:
  - IDLE: wait for start.
  - FETCH: drive the read address.
  - LOAD: capture the word; read pointer += 4.
  - SCAN: consume one symbol per cycle.
  - EMIT: write the record buffer; write pointer += 4.
  - FINISH: final flush; set done.
- Input symbols are packed little-endian. Symbol k of a word is bits [k·SYM_W +: SYM_W]; a word holds 32/SYM_W symbols.
- Record format: {symbol, count}, count in the low CNT_W bits; count = run length, 1..2^CNT_W−1.
- Records pack little-endian into the output word; a word holds RPW = 32/REC_W records.
- Transition table:
  - IDLE→FETCH on start with message_size≠0.
  - IDLE→FINISH on start with message_size=0.
  - LOAD→SCAN.
  - SCAN→FETCH when the word is exhausted and symbols remain.
  - SCAN→EMIT when the record buffer reaches RPW.
  - EMIT→SCAN or FETCH as applicable.
  - SCAN→FINISH after the last symbol; FINISH→IDLE.
- Record closes when any of these holds:
  - the symbol differs from the current run;
  - count = 2^CNT_W−1 (saturation: the next identical symbol starts a new record);
  - the last symbol has been consumed.
- FINISH:
  - writes any partial buffer, unused record slots = 0;
  - an empty buffer means no write.
- message_size=0: no RAM access; rle_size=0.
- Read and write never share a cycle. port_A_addr shows the write pointer when we=1, otherwise the read pointer.
- Address arithmetic is 16-bit and wraps modulo 2^16 with no error.
- start while busy is ignored.
- Reset mid-operation: all state returns to IDLE immediately and asynchronously, and port_A_we drops with it. No partial-word completion.

## Timing
- Reset values:
  - busy=0, done=0, error=0, rle_size=0;
  - port_A_we=0, port_A_addr=0, port_A_data_in=0.
- start sampled at edge N:
  - busy=1 and done=0 from N+1;
  - first read address driven in FETCH at N+1.
- Throughput:
  - each input word costs 2 cycles (FETCH, LOAD) + symbols-per-word SCAN cycles;
  - each output word adds 1 EMIT cycle.
- rle_size updates the cycle after each write.
- Completion: done=1 and busy=0 the cycle after FINISH, with final rle_size already valid.

## Configuration
- Macro: RLE_OVF_CHECK_EN.
- Defined:
  - Before each write, check that rle_size+4 > rle_max_size. If it holds, suppress the write, set error=1, and go to FINISH with no flush; done follows normally.
  - error clears on the next accepted start.
- Undefined: no check; rle_max_size is ignored; error is constant 0.

## Structure
- Shared package rle_pkg holds:
  - the state enum;
  - REC_W/RPW derivation and legality-check constants;
  - the record-pack function.
- One sub-module, rle_rec_packer: accumulates records into a 32-bit buffer and reports full/empty; cleared after each EMIT.
- The top level holds the FSM, pointers, and run counter.

## Test plan
- Defaults; message_size=4; word 0x41414141 → one write 0x00004104 at rle_addr; rle_size=4; done=1.
- message_size=0 → no port_A_we pulses; done two cycles after start; rle_size=0.
- 300 symbols of 0x00 → runs split at saturation (255, 45); single word 0x002D00FF; rle_size=4.
- message_size=5; words 0x11223344, 0x00000044 → writes 0x33014401, 0x11012201, 0x00004401; rle_size=12.
- RLE_OVF_CHECK_EN with rle_max_size=4 on the previous stimulus → one write only; error=1; rle_size=4; done=1.
- reset asserted during SCAN → port_A_we, busy, and done all 0 at once; a following start with the first stimulus completes correctly.
